// File: rtl/hdmi_mode_switch_controller.sv
// NTSC/PAL switch sequencer for the dual-timing HDMI path: debounce, blank,
// align to a frame start, pulse the timing-generator reset, swap mode, settle.
module hdmi_mode_switch_controller #(
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned SETTLE_FRAMES = 2,
    parameter int unsigned FRAME_TIMEOUT = 1048576
) (
    input  logic        clk_pixel,
    input  logic        reset_n,
    input  logic        pal_mode_req,
    input  logic [11:0] cx,
    input  logic [10:0] cy,
    output logic        pal_mode,
    output logic        hdmi_reset,
    output logic        blank,
    output logic        busy
);

    localparam int unsigned MIS_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned CYC_W = $clog2(RESET_CYCLES + 1);
    localparam int unsigned FRM_W = $clog2(SETTLE_FRAMES + 1);
    localparam int unsigned TO_W  = $clog2(FRAME_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAIN  = 2'd1,
        S_RESET  = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [MIS_W-1:0] mis_cnt;
    logic [CYC_W-1:0] cyc_cnt;
    logic [FRM_W-1:0] frm_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             target;

    logic fs_c;
    logic mismatch_c;
    logic stable_hit_c;
    logic timeout_c;
    logic frame_c;
    logic reset_done_c;
    logic settle_done_c;
    logic pal_mode_c;
    logic hdmi_reset_c;
    logic blank_c;
    logic busy_c;

    assign fs_c          = (cx == 12'd0) && (cy == 11'd0);
    assign mismatch_c    = (pal_mode_req != pal_mode);
    assign stable_hit_c  = (mis_cnt == MIS_W'(STABLE_CYCLES - 1));
    assign timeout_c     = (to_cnt == TO_W'(FRAME_TIMEOUT - 1));
    assign frame_c       = fs_c || timeout_c;
    assign reset_done_c  = (cyc_cnt == CYC_W'(RESET_CYCLES - 1));
    assign settle_done_c = (frm_cnt == FRM_W'(SETTLE_FRAMES - 1));

    // State register
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; withdrawal outranks a frame start in DRAIN
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (mismatch_c && stable_hit_c) state_d = S_DRAIN;
            S_DRAIN: begin
                if (!mismatch_c)  state_d = S_IDLE;
                else if (frame_c) state_d = S_RESET;
            end
            S_RESET:  if (reset_done_c) state_d = S_SETTLE;
            S_SETTLE: if (frame_c && settle_done_c) state_d = S_IDLE;
            default:  state_d = S_RESET;
        endcase
    end

    // Output next values, registered below
    always_comb begin
        pal_mode_c   = pal_mode;
        hdmi_reset_c = (state_d == S_RESET);
        blank_c      = (state_d != S_IDLE);
        busy_c       = (state_d != S_IDLE);
        if (state_q == S_DRAIN && state_d == S_RESET) begin
            pal_mode_c = target;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            pal_mode   <= 1'b0;
            hdmi_reset <= 1'b1;
            blank      <= 1'b1;
            busy       <= 1'b1;
        end else begin
            pal_mode   <= pal_mode_c;
            hdmi_reset <= hdmi_reset_c;
            blank      <= blank_c;
            busy       <= busy_c;
        end
    end

    // Counters: each clears on a state change, so none can wrap
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            mis_cnt <= '0;
            cyc_cnt <= '0;
            frm_cnt <= '0;
            to_cnt  <= '0;
            target  <= 1'b0;
        end else begin
            if (state_q == S_IDLE && mismatch_c && !stable_hit_c) begin
                mis_cnt <= mis_cnt + MIS_W'(1);
            end else begin
                mis_cnt <= '0;
            end

            if (state_q == S_IDLE && state_d == S_DRAIN) begin
                target <= pal_mode_req;
            end

            if (state_q == S_RESET && state_d == S_RESET) begin
                cyc_cnt <= cyc_cnt + CYC_W'(1);
            end else begin
                cyc_cnt <= '0;
            end

            if (state_q == S_SETTLE && state_d == S_SETTLE) begin
                if (frame_c) begin
                    frm_cnt <= frm_cnt + FRM_W'(1);
                end
            end else begin
                frm_cnt <= '0;
            end

            if (state_q == state_d && (state_q == S_DRAIN || state_q == S_SETTLE)
                && !frame_c) begin
                to_cnt <= to_cnt + TO_W'(1);
            end else begin
                to_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_mode_switch_controller.sv
// Directed bench for hdmi_mode_switch_controller with small timing parameters.
module tb_hdmi_mode_switch_controller;

    localparam int unsigned STABLE_CYCLES = 4;
    localparam int unsigned RESET_CYCLES  = 3;
    localparam int unsigned SETTLE_FRAMES = 2;
    localparam int unsigned FRAME_TIMEOUT = 64;
    localparam int          SEL_HR = 0;
    localparam int          SEL_BL = 1;

    logic        clk_pixel = 1'b0;
    logic        reset_n;
    logic        pal_mode_req;
    logic [11:0] cx;
    logic [10:0] cy;
    logic        pal_mode;
    logic        hdmi_reset;
    logic        blank;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int pix   = 10;
    bit frozen = 1'b0;

    hdmi_mode_switch_controller #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .RESET_CYCLES (RESET_CYCLES),
        .SETTLE_FRAMES(SETTLE_FRAMES),
        .FRAME_TIMEOUT(FRAME_TIMEOUT)
    ) dut (
        .clk_pixel   (clk_pixel),
        .reset_n     (reset_n),
        .pal_mode_req(pal_mode_req),
        .cx          (cx),
        .cy          (cy),
        .pal_mode    (pal_mode),
        .hdmi_reset  (hdmi_reset),
        .blank       (blank),
        .busy        (busy)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Frame is 20 pixels on line 0; frozen parks the scan away from 0,0
    task automatic drive();
        cx = frozen ? 12'd5 : 12'(pix);
        cy = frozen ? 11'd3 : 11'd0;
    endtask

    task automatic set_pix(input int v);
        pix = v;
        drive();
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
        pix = (pix == 19) ? 0 : pix + 1;
        drive();
    endtask

    function automatic logic sig_sel(input int sel);
        return (sel == SEL_HR) ? hdmi_reset : blank;
    endfunction

    task automatic wait_until(input string tag, input int sel, input logic val,
                              input int exp_n);
        int n = 0;
        while (sig_sel(sel) != val && n < exp_n + 50) begin
            tick();
            n++;
        end
        check(tag, n, exp_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int hr_seen;
        reset_n      = 1'b0;
        pal_mode_req = 1'b0;
        drive();
        repeat (3) tick();
        check("rst_pal",   pal_mode,   0);
        check("rst_hreset", hdmi_reset, 1);
        check("rst_blank", blank,      1);
        check("rst_busy",  busy,       1);

        // Power-up: 3-cycle reset pulse, then two frame starts in SETTLE
        reset_n = 1'b1;
        set_pix(10);
        wait_until("pu_hreset_len", SEL_HR, 1'b0, 3);
        check("pu_blank_in_settle", blank, 1);
        wait_until("pu_settle_len", SEL_BL, 1'b0, 28);
        check("pu_pal", pal_mode, 0);
        check("pu_busy", busy, 0);

        // Glitches shorter than the debounce window
        pal_mode_req = 1'b1;
        repeat (3) tick();
        check("glitch1_busy", busy, 0);
        pal_mode_req = 1'b0;
        tick();
        pal_mode_req = 1'b1;
        repeat (3) tick();
        check("glitch2_busy", busy, 0);
        pal_mode_req = 1'b0;
        repeat (5) tick();
        check("glitch_blank", blank, 0);
        check("glitch_pal", pal_mode, 0);

        // Normal switch to PAL aligned on a frame start
        set_pix(1);
        pal_mode_req = 1'b1;
        wait_until("sw_debounce", SEL_BL, 1'b1, 4);
        check("sw_drain_busy", busy, 1);
        check("sw_drain_pal", pal_mode, 0);
        check("sw_drain_hreset", hdmi_reset, 0);
        wait_until("sw_drain_len", SEL_HR, 1'b1, 16);
        check("sw_pal_on_reset", pal_mode, 1);
        wait_until("sw_hreset_len", SEL_HR, 1'b0, 3);
        wait_until("sw_settle_len", SEL_BL, 1'b0, 37);
        check("sw_idle_busy", busy, 0);
        check("sw_idle_pal", pal_mode, 1);

        // Withdrawal during DRAIN, then withdrawal coinciding with a frame start
        set_pix(1);
        pal_mode_req = 1'b0;
        wait_until("wd_debounce", SEL_BL, 1'b1, 4);
        pal_mode_req = 1'b1;
        tick();
        check("wd_blank", blank, 0);
        check("wd_busy", busy, 0);
        check("wd_hreset", hdmi_reset, 0);
        set_pix(1);
        pal_mode_req = 1'b0;
        wait_until("wdfs_debounce", SEL_BL, 1'b1, 4);
        set_pix(0);
        pal_mode_req = 1'b1;
        tick();
        check("wdfs_blank", blank, 0);
        check("wdfs_hreset", hdmi_reset, 0);
        hr_seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (hdmi_reset) hr_seen++;
        end
        check("wd_no_hreset", hr_seen, 0);
        check("wd_pal", pal_mode, 1);

        // Timeouts with the scan frozen away from the frame start
        frozen = 1'b1;
        drive();
        pal_mode_req = 1'b0;
        wait_until("to_debounce", SEL_BL, 1'b1, 4);
        wait_until("to_drain_len", SEL_HR, 1'b1, 64);
        check("to_pal", pal_mode, 0);
        wait_until("to_hreset_len", SEL_HR, 1'b0, 3);
        wait_until("to_settle_len", SEL_BL, 1'b0, 128);
        check("to_busy", busy, 0);

        // Reset mid-SETTLE after a switch to PAL, then re-switch via debounce
        frozen = 1'b0;
        set_pix(1);
        pal_mode_req = 1'b1;
        wait_until("mr_debounce", SEL_BL, 1'b1, 4);
        wait_until("mr_drain_len", SEL_HR, 1'b1, 16);
        wait_until("mr_hreset_len", SEL_HR, 1'b0, 3);
        repeat (5) tick();
        check("mr_pre_pal", pal_mode, 1);
        check("mr_pre_blank", blank, 1);
        reset_n = 1'b0;
        #1;
        check("mr_pal", pal_mode, 0);
        check("mr_hreset", hdmi_reset, 1);
        check("mr_blank", blank, 1);
        check("mr_busy", busy, 1);
        repeat (2) tick();
        reset_n = 1'b1;
        set_pix(10);
        wait_until("mr_pu_hreset", SEL_HR, 1'b0, 3);
        wait_until("mr_pu_settle", SEL_BL, 1'b0, 28);
        check("mr_pu_pal", pal_mode, 0);
        wait_until("mr_re_debounce", SEL_BL, 1'b1, 4);
        wait_until("mr_re_drain", SEL_HR, 1'b1, 16);
        check("mr_re_pal", pal_mode, 1);
        wait_until("mr_re_hreset", SEL_HR, 1'b0, 3);
        wait_until("mr_re_settle", SEL_BL, 1'b0, 37);
        check("mr_re_busy", busy, 0);
        check("mr_re_final_pal", pal_mode, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hdmi_mode_switch_controller.md
# hdmi_mode_switch_controller

Sequences NTSC/PAL video-standard changes for the dual-timing HDMI output path. Sits between the VDP register file (the requested mode) and the HDMI output selection stage, driving its `pal_mode` and `hdmi_reset` inputs. Each switch follows a fixed sequence: debounce the request, blank the picture, wait for a frame boundary, reset both HDMI timing generators, swap the mode, then keep the picture blanked for a settle period. The sink therefore never sees a torn frame or a mid-line timing change.

## Interface
- `STABLE_CYCLES`, 1024: consecutive mismatch cycles required before a request is accepted.
- `RESET_CYCLES`, 16: width of the `hdmi_reset` pulse, in `clk_pixel` cycles.
- `SETTLE_FRAMES`, 2: number of blanked frame starts after the reset.
- `FRAME_TIMEOUT`, 1048576: cycles without a frame start before one is forced.
- `clk_pixel` input 1: sole clock. Pixel clock of the HDMI path.
- `reset_n` input 1: asynchronous, active-low reset.
- `pal_mode_req` input 1: requested standard (1 = PAL). Already synchronous to `clk_pixel`.
- `cx` input 12: current pixel column from the HDMI selection stage.
- `cy` input 11: current line from the HDMI selection stage.
- `pal_mode` output 1: applied standard. Registered.
- `hdmi_reset` output 1: reset to the HDMI timing generators. Active-high, registered.
- `blank` output 1: forces RGB to black upstream. Registered.
- `busy` output 1: high whenever the state is not IDLE. Registered.

## Operation
- Frame start (`fs`) is defined as `cx==0 && cy==0`, sampled on the clock edge.
- States: IDLE, DRAIN, RESET, SETTLE. Every output is a registered function of the state, with values as listed below.
- Reset (`reset_n` low, asynchronous): state RESET, cycle counter 0, `pal_mode`=0, `hdmi_reset`=1, `blank`=1, `busy`=1.
  - Startup therefore runs RESET → SETTLE → IDLE in NTSC.
- IDLE (`hdmi_reset`=0, `blank`=0, `busy`=0):
  - The mismatch counter increments on each cycle where `pal_mode_req != pal_mode`, and clears to 0 on any match.
  - When the STABLE_CYCLES-th consecutive mismatch cycle is sampled, the block latches `target = pal_mode_req` and enters DRAIN.
- DRAIN (`blank`=1, `busy`=1, `pal_mode` unchanged):
  - If `pal_mode_req == pal_mode`, the request was withdrawn. Return to IDLE with no reset pulse; `blank` deasserts on the next edge.
  - Otherwise, on `fs` or when the timeout counter reaches FRAME_TIMEOUT-1, go to RESET. On that same edge `pal_mode` <= `target` and `hdmi_reset` <= 1.
  - Withdrawal has priority over `fs` when both occur in the same cycle.
- RESET (`hdmi_reset`=1):
  - The cycle counter counts RESET_CYCLES cycles.
  - On the edge ending the last cycle, `hdmi_reset` <= 0, the frame counter clears, and the state becomes SETTLE.
- SETTLE (`blank`=1, `busy`=1):
  - Count `fs` events. A timeout with no `fs` counts as one frame, and the timeout counter restarts on every counted frame.
  - On the SETTLE_FRAMES-th counted frame, go to IDLE. `blank` and `busy` go to 0 on that edge.
- Request changes during RESET or SETTLE are ignored. The mismatch counter is held at 0 outside IDLE, so a pending request is re-debounced from IDLE.
- Counter widths: each counter is sized $clog2(limit+1). The timeout counter restarts on entry to DRAIN and SETTLE. No counter wraps: each saturates or is cleared by a state transition.
- `reset_n` asserted mid-sequence aborts immediately to the reset values, so `pal_mode` returns to 0.

## Timing
- Request to DRAIN: exactly STABLE_CYCLES cycles of stable mismatch. `blank` and `busy` rise on the edge that samples the last mismatch cycle.
- DRAIN to RESET: 1 cycle after the sampled `fs`, or FRAME_TIMEOUT cycles after DRAIN entry.
- `hdmi_reset` is high for exactly RESET_CYCLES cycles.
- `pal_mode` changes on the same edge that `hdmi_reset` rises, never while `hdmi_reset`=0.
- `blank`=1 throughout DRAIN, RESET and SETTLE.
  - `blank`=0 only in IDLE, so it spans from the DRAIN entry edge to the SETTLE exit edge.
- `busy` tracks `blank` exactly.
- After `reset_n` deasserts: RESET_CYCLES cycles of `hdmi_reset`, then SETTLE_FRAMES frame starts, then IDLE.

## Test plan
Bench parameters: STABLE_CYCLES=4, RESET_CYCLES=3, SETTLE_FRAMES=2, FRAME_TIMEOUT=64.

- Power-up: release `reset_n` with `fs` every 20 cycles.
  - Required: `hdmi_reset` high 3 cycles, `blank` clears at the 2nd `fs`, `pal_mode`=0, `busy`=0.
- Normal switch: in IDLE, set `pal_mode_req`=1.
  - Required: `blank` rises after 4 cycles, and `pal_mode`=1 with `hdmi_reset`=1 one cycle after the next `fs`.
  - Required: 3-cycle reset pulse, then IDLE after 2 further `fs`.
- Glitch: pulse `pal_mode_req`=1 for 3 cycles, then back to 0.
  - Required: no state change; `busy` stays 0.
- Withdrawal: enter DRAIN, then drop `pal_mode_req` before any `fs`.
  - Required: return to IDLE next cycle, `pal_mode` stays 0, `hdmi_reset` never asserted.
- Timeout: enter DRAIN with `cx`/`cy` frozen at nonzero values.
  - Required: RESET entered exactly 64 cycles after DRAIN entry.
  - Required: SETTLE exits after 2×64 cycles.
- Mid-sequence reset: assert `reset_n` low during SETTLE after a switch to PAL.
  - Required: outputs go immediately to `pal_mode`=0, `hdmi_reset`=1, `blank`=1.
  - Required: then re-switch to PAL via the debounce path, since `pal_mode_req` is still 1.
